seq_tx: RTL

SEQ_TX -- requirements
Module: seq_tx

---
 rtl/seq_pkg.sv | 13 +
 rtl/seq_tx.sv | 106 ++++++++++
 2 files changed

// File: rtl/seq_pkg.sv
// Shared types and constants for the serial pattern transmitter.
package seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_GAP   = 2'b10,
        ST_DONE  = 2'b11
    } state_t;

    localparam logic [3:0] DEF_PATTERN = 4'b1011;

endpackage

// File: rtl/seq_tx.sv
// Serial pattern transmitter: sends a WIDTH-bit frame MSB first, repeat_cnt
// times, with GAP idle cycles between frames, then pulses done.
module seq_tx
    import seq_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int GAP   = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] pattern,
    // frame count; "repeat" itself is a reserved word in SystemVerilog
    input  logic [3:0]       repeat_cnt,
    output logic             seq_out,
    output logic             seq_valid,
    output logic             busy,
    output logic             done
);

    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t           state, nxt_state;
    logic [WIDTH-1:0] sh, nxt_sh;
    logic [WIDTH-1:0] pat_q, nxt_pat;
    logic [3:0]       frames, nxt_frames;
    logic [BW-1:0]    bitc, nxt_bitc;
    logic [3:0]       gapc, nxt_gapc;

    always_comb begin
        nxt_state  = state;
        nxt_sh     = sh;
        nxt_pat    = pat_q;
        nxt_frames = frames;
        nxt_bitc   = bitc;
        nxt_gapc   = gapc;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    nxt_sh     = pattern;
                    nxt_pat    = pattern;
                    nxt_frames = repeat_cnt;
                    nxt_bitc   = '0;
                    nxt_gapc   = '0;
                    nxt_state  = (repeat_cnt != 4'd0) ? ST_SHIFT : ST_DONE;
                end
            end
            ST_SHIFT: begin
                if (bitc == BW'(WIDTH - 1)) begin
                    nxt_frames = frames - 4'd1;
                    nxt_bitc   = '0;
                    if (frames == 4'd1) begin
                        nxt_state = ST_DONE;
                    end else if (GAP > 0) begin
                        nxt_state = ST_GAP;
                        nxt_gapc  = '0;
                    end else begin
                        // back-to-back frame: reload with no bubble
                        nxt_sh = pat_q;
                    end
                end else begin
                    nxt_sh   = sh << 1;
                    nxt_bitc = bitc + 1'b1;
                end
            end
            ST_GAP: begin
                if (gapc == 4'(GAP - 1)) begin
                    nxt_state = ST_SHIFT;
                    nxt_sh    = pat_q;
                end else begin
                    nxt_gapc = gapc + 4'd1;
                end
            end
            default: nxt_state = ST_IDLE;
        endcase
    end

    // Outputs are registered from the next-state values so the first frame
    // bit shows up the cycle right after start is sampled.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= ST_IDLE;
            sh        <= '0;
            pat_q     <= '0;
            frames    <= '0;
            bitc      <= '0;
            gapc      <= '0;
            seq_out   <= 1'b0;
            seq_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= nxt_state;
            sh        <= nxt_sh;
            pat_q     <= nxt_pat;
            frames    <= nxt_frames;
            bitc      <= nxt_bitc;
            gapc      <= nxt_gapc;
            seq_out   <= (nxt_state == ST_SHIFT) && nxt_sh[WIDTH-1];
            seq_valid <= (nxt_state == ST_SHIFT);
            busy      <= (nxt_state != ST_IDLE);
            done      <= (nxt_state == ST_DONE);
        end
    end

endmodule
